// File: rtl/mem_pkg.sv
// Shared encodings for the memory-access stage: funct3 codes, FSM states,
// byte-enable patterns and alignment/byte-enable helpers.
package mem_pkg;

  localparam int unsigned XLEN_W = 32;

  // Access size and sign (funct3); stores reuse F3_B/F3_H/F3_W
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  // Byte-enable patterns before shifting by the address offset
  localparam logic [3:0] BE_B = 4'b0001;
  localparam logic [3:0] BE_H = 4'b0011;
  localparam logic [3:0] BE_W = 4'b1111;

  // Halfwords need an even offset, words need offset 0
  function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] off);
    logic bad;
    case (f3[1:0])
      2'b01:   bad = off[0];
      2'b10:   bad = (off != 2'b00);
      default: bad = 1'b0;
    endcase
    return bad;
  endfunction

  // Lane mask for the access size at the given offset
  function automatic logic [3:0] byte_enable(input logic [2:0] f3, input logic [1:0] off);
    logic [3:0] be;
    case (f3[1:0])
      2'b00:   be = BE_B << off;
      2'b01:   be = BE_H << off;
      default: be = BE_W;
    endcase
    return be;
  endfunction

endpackage

// File: rtl/mem_stage_if.sv
// Execute-stage handoff, data-memory port and writeback signals of mem_stage.
// slave = the memory stage itself, master = its surroundings.
interface mem_stage_if;
  import mem_pkg::*;

  logic              in_valid;
  logic              in_ready;
  logic [XLEN_W-1:0] alu_res;
  logic              zero;
  logic [XLEN_W-1:0] mux1in;
  logic [XLEN_W-1:0] store_data;
  logic [4:0]        rd;
  logic [2:0]        funct3;
  logic              mem_read;
  logic              mem_write;
  logic              branch;
  logic              reg_write;

  logic              dmem_req;
  logic              dmem_we;
  logic [XLEN_W-1:0] dmem_addr;
  logic [3:0]        dmem_be;
  logic [XLEN_W-1:0] dmem_wdata;
  logic              dmem_ack;
  logic [XLEN_W-1:0] dmem_rdata;

  logic              pc_src;
  logic [XLEN_W-1:0] branch_target;
  logic              wb_valid;
  logic              wb_reg_write;
  logic [4:0]        wb_rd;
  logic [XLEN_W-1:0] wb_data;
  logic              misalign;
  logic              bus_err;

  modport slave (
    input  in_valid, alu_res, zero, mux1in, store_data, rd, funct3,
           mem_read, mem_write, branch, reg_write, dmem_ack, dmem_rdata,
    output in_ready, dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
           pc_src, branch_target, wb_valid, wb_reg_write, wb_rd, wb_data,
           misalign, bus_err
  );

  modport master (
    output in_valid, alu_res, zero, mux1in, store_data, rd, funct3,
           mem_read, mem_write, branch, reg_write, dmem_ack, dmem_rdata,
    input  in_ready, dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
           pc_src, branch_target, wb_valid, wb_reg_write, wb_rd, wb_data,
           misalign, bus_err
  );

endinterface

// File: rtl/mem_stage_load_align.sv
// Selects the addressed byte/half of a load word and sign- or zero-extends it.
module load_align
  import mem_pkg::*;
(
  input  logic [XLEN_W-1:0] rdata,
  input  logic [1:0]        offset,
  input  logic [2:0]        funct3,
  output logic [XLEN_W-1:0] data
);

  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  // Lane extraction followed by extension chosen by funct3
  always_comb begin
    lane_b = rdata[{offset, 3'b000} +: 8];
    lane_h = rdata[{offset[1], 4'b0000} +: 16];
    case (funct3)
      F3_B:    data = {{24{lane_b[7]}}, lane_b};
      F3_BU:   data = {24'h0, lane_b};
      F3_H:    data = {{16{lane_h[15]}}, lane_h};
      F3_HU:   data = {16'h0, lane_h};
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// Memory-access stage: captures execute results, resolves branches, runs
// loads/stores on a req/ack port with timeout and emits one writeback beat.
module mem_stage
  import mem_pkg::*;
#(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned TIMEOUT = 16
) (
  input logic       clk,
  input logic       rst,
  mem_stage_if.slave bus
);

  localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       cap_f3;
  logic [1:0]       cap_off;
  logic             cap_load;
  logic             cap_rw;

  logic             mem_op;
  logic             bad_align;
  logic [XLEN-1:0]  load_val;
  logic [XLEN-1:0]  wdata_rep;

  assign mem_op      = bus.mem_read | bus.mem_write;
  assign bad_align   = is_misaligned(bus.funct3, bus.alu_res[1:0]);
  assign bus.in_ready = (state == IDLE) & ~rst;

  // Store data replicated across every lane of its access size
  always_comb begin
    case (bus.funct3[1:0])
      2'b00:   wdata_rep = {4{bus.store_data[7:0]}};
      2'b01:   wdata_rep = {2{bus.store_data[15:0]}};
      default: wdata_rep = bus.store_data;
    endcase
  end

  load_align u_load_align (
    .rdata  (bus.dmem_rdata),
    .offset (cap_off),
    .funct3 (cap_f3),
    .data   (load_val)
  );

  // Stage FSM with registered pulses, memory port and writeback beat
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state             <= IDLE;
      cnt               <= '0;
      cap_f3            <= '0;
      cap_off           <= '0;
      cap_load          <= 1'b0;
      cap_rw            <= 1'b0;
      bus.dmem_req      <= 1'b0;
      bus.dmem_we       <= 1'b0;
      bus.dmem_addr     <= '0;
      bus.dmem_be       <= '0;
      bus.dmem_wdata    <= '0;
      bus.pc_src        <= 1'b0;
      bus.branch_target <= '0;
      bus.wb_valid      <= 1'b0;
      bus.wb_reg_write  <= 1'b0;
      bus.wb_rd         <= '0;
      bus.wb_data       <= '0;
      bus.misalign      <= 1'b0;
      bus.bus_err       <= 1'b0;
    end else begin
      bus.wb_valid     <= 1'b0;
      bus.wb_reg_write <= 1'b0;
      bus.pc_src       <= 1'b0;
      bus.misalign     <= 1'b0;
      bus.bus_err      <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            bus.wb_rd         <= bus.rd;
            bus.branch_target <= bus.mux1in;
            bus.pc_src        <= bus.branch & bus.zero;
            cap_f3            <= bus.funct3;
            cap_off           <= bus.alu_res[1:0];
            cap_load          <= bus.mem_read;
            cap_rw            <= bus.reg_write;
            if (mem_op && bad_align) begin
              bus.misalign <= 1'b1;
              bus.wb_valid <= 1'b1;
            end else if (mem_op) begin
              state          <= ACCESS;
              cnt            <= '0;
              bus.dmem_req   <= 1'b1;
              bus.dmem_we    <= bus.mem_write;
              bus.dmem_addr  <= {bus.alu_res[31:2], 2'b00};
              bus.dmem_be    <= byte_enable(bus.funct3, bus.alu_res[1:0]);
              bus.dmem_wdata <= wdata_rep;
            end else begin
              bus.wb_valid     <= 1'b1;
              bus.wb_data      <= bus.alu_res;
              bus.wb_reg_write <= bus.reg_write & ~bus.branch;
            end
          end
        end
        ACCESS: begin
          if (bus.dmem_ack) begin
            state            <= RESP;
            cnt              <= '0;
            bus.dmem_req     <= 1'b0;
            bus.wb_valid     <= 1'b1;
            bus.wb_reg_write <= cap_load & cap_rw;
            if (cap_load) bus.wb_data <= load_val;
          end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
            state        <= IDLE;
            cnt          <= '0;
            bus.dmem_req <= 1'b0;
            bus.bus_err  <= 1'b1;
            bus.wb_valid <= 1'b1;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
